// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave
//   AHB-Lite subordinate in front of a word-organised memory. It adds a
//   programmable number of wait states before each OKAY data phase, byte and
//   halfword write lanes, and the two-cycle ERROR response for illegal
//   transfers. Every transfer the master issues is completed.
//
// Parameters
//   DEPTH        number of 32-bit memory words (power of 2)
//   WAIT_STATES  hreadyout-low cycles before each OKAY data phase (0..15)
//
// Ports
//   hclk, hresetn      clock; synchronous active-low reset
//   hsel               select line from the address decoder
//   haddr, hwrite,     address-phase controls
//   hsize, htrans,
//   hburst, hprot,
//   hmastlock
//   hready             bus-wide ready (qualifies the address phase)
//   hwdata             write data (data phase)
//   hreadyout, hresp,  data-phase response back through the slave mux
//   hrdata
//
// Handshake: an address phase is taken on a rising edge where
// hsel & hready & htrans[1]. Its data phase ends on the first rising edge at
// which hreadyout is high; hresp and hrdata are meaningful in that cycle.
module ahb_lite_mem_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Counter load value; only used when WAIT_STATES > 0.
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]        state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] word_r;
  logic [1:0]        lane_r;
  logic [1:0]        size_r;
  logic              write_r;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              can_accept;
  logic              take;
  logic              addr_err;
  logic [3:0]        byte_en;

  // Burst type, protection, lock and htrans[0] carry no meaning here: every
  // beat is treated as a single transfer addressed by haddr.
  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

  assign accept = hsel & hready & htrans[1];

  // Only the states that drive hreadyout high may start a new address phase;
  // unused encodings behave like IDLE so the FSM always recovers.
  assign can_accept = (state != ST_WAIT) && (state != ST_ERR1);
  assign take       = accept & can_accept;

  assign addr_err = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (|haddr[1:0]))
                  | (|haddr[31:ADDR_W+2]);

  // Control FSM and wait-state counter.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          // IDLE, DONE and ERR2: the previous data phase (if any) ends here,
          // so the next transfer starts with no bubble.
          if (take) begin
            if (addr_err) begin
              state <= ST_ERR1;
            end else if (WAIT_STATES == 0) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Address-phase capture.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      word_r  <= '0;
      lane_r  <= 2'd0;
      size_r  <= 2'd0;
      write_r <= 1'b0;
    end else if (take) begin
      word_r  <= haddr[ADDR_W+1:2];
      lane_r  <= haddr[1:0];
      size_r  <= hsize[1:0];
      write_r <= hwrite;
    end
  end

  // Little-endian byte enables; data arrives on its natural lanes of hwdata.
  always_comb begin
    byte_en = 4'b0000;
    case (size_r)
      2'd0:    byte_en = 4'b0001 << lane_r;
      2'd1:    byte_en = lane_r[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Writes commit only at the DONE edge. Errored transfers never reach DONE,
  // and a reset on that edge drops the write.
  always_ff @(posedge hclk) begin
    if (hresetn && (state == ST_DONE) && write_r) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_r][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  // Responses decode straight from state. The read is asynchronous so a read
  // whose DONE follows a write's DONE sees the freshly committed word.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    case (state)
      ST_WAIT: hreadyout = 1'b0;
      ST_DONE: hrdata    = mem[word_r];
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave. Three instances (0, 2 and 3 wait states)
// share one AHB-Lite bus; each has its own hsel and hready follows the
// slave that owns the current data phase.
module tb_ahb_lite_mem_slave;

  localparam int NS    = 3;
  localparam int DEPTH = 256;
  localparam int GUARD = 500;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hready;
  logic [31:0] hwdata;
  logic [2:0]  ro;
  logic [2:0]  rs;
  logic [31:0] rd [NS];
  logic [1:0]  dsel;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: byte-addressed memory per slave plus a written flag.
  logic [7:0] mdl  [NS][DEPTH*4];
  bit         mval [NS][DEPTH*4];

  xfer_t       sq [$];
  logic [31:0] r_rdata [$];
  logic [31:0] r_early [$];
  logic [15:0] r_ro [$];
  logic [15:0] r_rs [$];
  int          r_cyc [$];
  int          seq_edges;

  always #5 hclk = ~hclk;

  assign hready = ro[dsel];

  for (genvar g = 0; g < NS; g++) begin : g_dut
    ahb_lite_mem_slave #(
      .DEPTH      (DEPTH),
      .WAIT_STATES((g == 0) ? 0 : g + 1)
    ) u_dut (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .hsel     (hsel[g]),
      .haddr    (haddr),
      .hwrite   (hwrite),
      .hsize    (hsize),
      .hburst   (hburst),
      .hprot    (hprot),
      .htrans   (htrans),
      .hmastlock(hmastlock),
      .hready   (hready),
      .hwdata   (hwdata),
      .hreadyout(ro[g]),
      .hresp    (rs[g]),
      .hrdata   (rd[g])
    );
  end

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : s + 1;
  endfunction

  // Applies one transfer to the model; returns whether it must error and,
  // for reads, the expected word. Errors expect hrdata = 0.
  function automatic void model_step(input int s, input xfer_t x, output bit err,
                                     output logic [31:0] rword, output bit rvalid);
    int base;
    int a;
    err = (x.size > 3'd2) || (x.addr >= 32'(DEPTH*4)) ||
          ((x.addr % (32'd1 << x.size)) != 0);
    rword  = 32'h0;
    rvalid = 1'b0;
    if (!err) begin
      if (x.wr) begin
        for (int b = 0; b < (1 << x.size); b++) begin
          a = int'(x.addr) + b;
          mdl[s][a]  = x.wdata[8*(a%4) +: 8];
          mval[s][a] = 1'b1;
        end
      end else begin
        base   = int'(x.addr) & ~3;
        rvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
          rword[8*b +: 8] = mdl[s][base+b];
          rvalid          = rvalid & mval[s][base+b];
        end
      end
    end
  endfunction

  // Expected data-phase shape: {cycles, hreadyout trace, hresp trace, early hrdata}.
  function automatic logic [40:0] exp_shape(input int s, input bit err);
    if (err) return {8'd2, 16'b01, 16'b11, 1'b0};
    return {8'(ws_of(s) + 1), 16'd1, 16'd0, 1'b0};
  endfunction

  function automatic logic [40:0] obs_shape(input int i);
    return {8'(r_cyc[i]), r_ro[i], r_rs[i], |r_early[i]};
  endfunction

  function automatic xfer_t mk(input logic wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  task automatic drive_addr(input int s, input int i, input int n);
    hburst    = 3'($urandom_range(0, 7));
    hprot     = 4'($urandom_range(0, 15));
    hmastlock = 1'($urandom_range(0, 1));
    if (i < n) begin
      hsel   = 3'(1 << s);
      haddr  = sq[i].addr;
      hwrite = sq[i].wr;
      hsize  = sq[i].size;
      htrans = (i == 0) ? 2'b10 : 2'b11;
    end else begin
      hsel   = 3'b000;
      htrans = 2'b00;
      haddr  = $urandom;
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'd0;
    end
  endtask

  // Issues every transfer in sq to slave s back-to-back and records each
  // data phase as seen by the master.
  task automatic run_seq(input int s);
    int          n, issue, cur, guard, cyc;
    logic [15:0] tro, trs;
    logic [31:0] early, last_rd;
    bit          rdy;
    n = sq.size(); issue = 0; cur = -1; guard = 0; cyc = 0;
    tro = '0; trs = '0; early = '0; last_rd = '0;
    r_rdata.delete(); r_early.delete(); r_ro.delete(); r_rs.delete(); r_cyc.delete();
    dsel = 2'(s);
    drive_addr(s, issue, n);
    while ((issue < n || cur >= 0) && guard < GUARD) begin
      @(negedge hclk);
      rdy = hready;
      if (cur >= 0) begin
        cyc++;
        tro = {tro[14:0], ro[s]};
        trs = {trs[14:0], rs[s]};
        if (!rdy) early = early | rd[s];
        last_rd = rd[s];
      end
      @(posedge hclk);
      #1;
      guard++;
      if (rdy) begin
        if (cur >= 0) begin
          r_rdata.push_back(last_rd); r_early.push_back(early);
          r_ro.push_back(tro); r_rs.push_back(trs); r_cyc.push_back(cyc);
        end
        cur = -1;
        if (issue < n) begin
          cur    = issue;
          hwdata = sq[issue].wdata;
          issue++;
        end
        cyc = 0; tro = '0; trs = '0; early = '0;
        drive_addr(s, issue, n);
      end
    end
    seq_edges = guard;
    if (guard >= GUARD) begin
      vectors++; miscompares++;
      $display("FAIL seq_timeout slave %0d: got %0d edges, required < %0d", s, guard, GUARD);
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0; hsel = 3'b000; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = '0; dsel = 2'd0;
    repeat (3) @(posedge hclk);
    #1;
    for (int s = 0; s < NS; s++) begin
      vectors++;
      if ({ro[s], rs[s], rd[s]} !== {1'b1, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL reset slave %0d: got ro=%b rs=%b rd=%h, required 1 0 0", s, ro[s], rs[s], rd[s]);
      end
    end
    hresetn = 1'b1;
  endtask

  task automatic test_write_word();
    bit e_err, e_rv; logic [31:0] e_rd;
    for (int s = 0; s < NS; s++) begin
      sq = '{mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF), mk(1'b0, 32'h10, 3'd2, 32'h0)};
      run_seq(s);
      foreach (sq[i]) begin
        model_step(s, sq[i], e_err, e_rd, e_rv);
        vectors++;
        if (obs_shape(i) !== exp_shape(s, e_err)) begin
          miscompares++;
          $display("FAIL write_word shape s%0d[%0d]: got %h, required %h", s, i, obs_shape(i), exp_shape(s, e_err));
        end
      end
      vectors++;
      if (r_rdata[1] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL write_word read s%0d: got %h, required deadbeef", s, r_rdata[1]);
      end
    end
  endtask

  task automatic test_wait_states();
    bit e_err, e_rv; logic [31:0] e_rd;
    sq = '{mk(1'b0, 32'h10, 3'd2, 32'h0)};
    run_seq(1);
    model_step(1, sq[0], e_err, e_rd, e_rv);
    vectors++;
    if (r_cyc[0] !== 3 || r_ro[0] !== 16'b001 || r_rs[0] !== 16'b000) begin
      miscompares++;
      $display("FAIL wait_states pattern: got cyc=%0d ro=%b rs=%b, required 3 001 000", r_cyc[0], r_ro[0][2:0], r_rs[0][2:0]);
    end
    vectors++;
    if (r_early[0] !== 32'h0 || r_rdata[0] !== e_rd) begin
      miscompares++;
      $display("FAIL wait_states data: got early=%h rd=%h, required 0 %h", r_early[0], r_rdata[0], e_rd);
    end
  endtask

  task automatic test_byte_lanes();
    bit e_err, e_rv; logic [31:0] e_rd;
    sq = '{mk(1'b1, 32'h20, 3'd2, 32'h00000000), mk(1'b1, 32'h21, 3'd0, 32'h0000AA00),
           mk(1'b1, 32'h22, 3'd1, 32'h12340000), mk(1'b0, 32'h20, 3'd2, 32'h0)};
    run_seq(0);
    foreach (sq[i]) begin
      model_step(0, sq[i], e_err, e_rd, e_rv);
      vectors++;
      if (obs_shape(i) !== exp_shape(0, e_err)) begin
        miscompares++;
        $display("FAIL byte_lanes shape[%0d]: got %h, required %h", i, obs_shape(i), exp_shape(0, e_err));
      end
    end
    vectors++;
    if (r_rdata[3] !== 32'h1234AA00) begin
      miscompares++;
      $display("FAIL byte_lanes read: got %h, required 1234aa00", r_rdata[3]);
    end
  endtask

  task automatic test_errors();
    bit e_err, e_rv; logic [31:0] e_rd;
    for (int s = 0; s < 2; s++) begin
      sq = '{mk(1'b1, 32'h13, 3'd2, 32'hFFFFFFFF), mk(1'b1, 32'h20, 3'd3, 32'hFFFFFFFF),
             mk(1'b1, 32'h400, 3'd2, 32'hFFFFFFFF), mk(1'b0, 32'h10, 3'd2, 32'h0)};
      run_seq(s);
      foreach (sq[i]) begin
        model_step(s, sq[i], e_err, e_rd, e_rv);
        vectors++;
        if (obs_shape(i) !== exp_shape(s, e_err)) begin
          miscompares++;
          $display("FAIL errors shape s%0d[%0d]: got %h, required %h", s, i, obs_shape(i), exp_shape(s, e_err));
        end
        vectors++;
        if (r_rdata[i] !== e_rd) begin
          miscompares++;
          $display("FAIL errors rdata s%0d[%0d]: got %h, required %h", s, i, r_rdata[i], e_rd);
        end
      end
    end
  endtask

  task automatic test_pipelined();
    bit e_err, e_rv; logic [31:0] e_rd;
    sq = '{mk(1'b1, 32'h30, 3'd2, 32'h00000055), mk(1'b0, 32'h30, 3'd2, 32'h0)};
    run_seq(0);
    vectors++;
    if (seq_edges !== 3) begin
      miscompares++;
      $display("FAIL pipelined edges: got %0d, required 3", seq_edges);
    end
    foreach (sq[i]) model_step(0, sq[i], e_err, e_rd, e_rv);
    vectors++;
    if (r_rdata[1] !== 32'h00000055 || r_cyc[1] !== 1) begin
      miscompares++;
      $display("FAIL pipelined read: got %h cyc=%0d, required 00000055 cyc=1", r_rdata[1], r_cyc[1]);
    end
  endtask

  task automatic test_idle_busy();
    bit e_err, e_rv; logic [31:0] e_rd;
    dsel = 2'd0;
    for (int c = 0; c < 8; c++) begin
      hsel   = ((c % 4) < 2) ? 3'b111 : 3'b000;
      htrans = 2'((c % 4 == 0) ? 1 : (c % 4 == 1) ? 0 : (c % 4 == 2) ? 2 : 3);
      haddr  = 32'h10; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
      @(posedge hclk);
      #1;
      for (int s = 0; s < NS; s++) begin
        vectors++;
        if ({ro[s], rs[s], rd[s]} !== {1'b1, 1'b0, 32'h0}) begin
          miscompares++;
          $display("FAIL idle_busy c%0d s%0d: got ro=%b rs=%b rd=%h, required 1 0 0", c, s, ro[s], rs[s], rd[s]);
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      sq = '{mk(1'b0, 32'h10, 3'd2, 32'h0)};
      run_seq(s);
      model_step(s, sq[0], e_err, e_rd, e_rv);
      vectors++;
      if (r_rdata[0] !== e_rd) begin
        miscompares++;
        $display("FAIL idle_busy reread s%0d: got %h, required %h", s, r_rdata[0], e_rd);
      end
    end
  endtask

  // Reset during WAIT (3 wait states) and during DONE (0 wait states).
  task automatic test_reset_midxfer();
    bit e_err, e_rv; logic [31:0] e_rd;
    int s;
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? 2 : 0;
      dsel = 2'(s); hsel = 3'(1 << s); haddr = 32'h10; hwrite = 1'b1;
      hsize = 3'd2; htrans = 2'b10; hwdata = 32'hFFFFFFFF;
      @(posedge hclk);
      #1;
      hsel = 3'b000; htrans = 2'b00;
      vectors++;
      if (ro[s] !== ((ws_of(s) == 0) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL midxfer phase s%0d: got ro=%b, required %b", s, ro[s], (ws_of(s) == 0));
      end
      if (k == 0) begin
        @(posedge hclk);
        #1;
      end
      hresetn = 1'b0;
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      vectors++;
      if ({ro[s], rs[s], rd[s]} !== {1'b1, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL midxfer reset s%0d: got ro=%b rs=%b rd=%h, required 1 0 0", s, ro[s], rs[s], rd[s]);
      end
      sq = '{mk(1'b0, 32'h10, 3'd2, 32'h0)};
      run_seq(s);
      model_step(s, sq[0], e_err, e_rd, e_rv);
      vectors++;
      if (r_rdata[0] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL midxfer reread s%0d: got %h, required deadbeef", s, r_rdata[0]);
      end
    end
  endtask

  task automatic test_random();
    bit e_err, e_rv; logic [31:0] e_rd;
    logic [31:0] exp_q [$];
    xfer_t x;
    int r;
    for (int s = 0; s < NS; s++) begin
      sq.delete();
      for (int w = 0; w < 16; w++) sq.push_back(mk(1'b1, 32'h100 + 32'(4*w), 3'd2, $urandom));
      for (int i = 0; i < 40; i++) begin
        x.wr    = 1'($urandom_range(0, 1));
        x.size  = 3'($urandom_range(0, 2));
        x.addr  = (32'h100 + 32'($urandom_range(0, 63))) & ~((32'd1 << x.size) - 32'd1);
        x.wdata = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0) x.size = 3'($urandom_range(3, 7));
        if (r == 1) x.addr = x.addr | (32'd1 << $urandom_range(10, 31));
        if (r == 2 && x.size != 3'd0) x.addr = x.addr | 32'd1;
        sq.push_back(x);
      end
      run_seq(s);
      foreach (sq[i]) begin
        model_step(s, sq[i], e_err, e_rd, e_rv);
        vectors++;
        if (obs_shape(i) !== exp_shape(s, e_err)) begin
          miscompares++;
          $display("FAIL random shape s%0d[%0d]: got %h, required %h", s, i, obs_shape(i), exp_shape(s, e_err));
        end
        if (e_rv || e_err) exp_q.push_back(e_rd);
        if (e_rv || e_err) begin
          vectors++;
          if (r_rdata[i] !== exp_q.pop_front()) begin
            miscompares++;
            $display("FAIL random rdata s%0d[%0d] addr %h: got %h, required %h", s, i, sq[i].addr, r_rdata[i], e_rd);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_word();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_pipelined();
    test_idle_busy();
    test_reset_midxfer();
    test_random();
    repeat (2) @(posedge hclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite subordinate with word-organised memory behind it, one instance per decoder select line.
- Answers transfers from the bus master through the slave-to-master multiplexor.
- Adds a programmable wait-state counter, byte/halfword write lanes, and the two-cycle ERROR response.
- Completes every transfer the master issues; the master stays simple.

Parameters:
DEPTH, 256, number of 32-bit memory words (power of 2); ADDR_W = log2(DEPTH) derived internally
WAIT_STATES, 0, hreadyout-low cycles inserted before each OKAY data phase completes (0..15)

Ports:
hclk  input  1  clock, all state updates on rising edge
hresetn  input  1  reset, synchronous, active-low
hsel  input  1  slave select from decoder
haddr  input  32  byte address (address phase)
hwrite  input  1  1=write, 0=read (address phase)
hsize  input  3  transfer size (0=byte, 1=half, 2=word, >2 illegal)
hburst  input  3  burst type; accepted, not checked
hprot  input  4  protection; ignored
htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
hmastlock  input  1  ignored
hready  input  1  bus-wide ready; address phase valid only when high
hwdata  input  32  write data (data phase)
hreadyout  output  1  transfer-done flag for current data phase
hresp  output  1  0=OKAY, 1=ERROR
hrdata  output  32  read data (data phase)

Behaviour:
- Reset:
  - hresetn low at a rising edge puts the block in IDLE.
  - Outputs after reset: hreadyout=1, hresp=0, hrdata=0. The wait counter clears.
  - Memory contents are not cleared.
  - Reset mid-transfer abandons the transfer and commits no write.
- Address phase accept:
  - Condition is hsel & hready & htrans[1] at a rising edge.
  - On accept, register haddr, hwrite, hsize, and the error flag.
  - IDLE/BUSY with hsel=1, and any cycle with hsel=0, accept nothing. Next cycle: hreadyout=1, hresp=0.
- Error flag is set when any of these holds:
  - hsize>2
  - hsize=1 and haddr[0]=1
  - hsize=2 and haddr[1:0]!=0
  - haddr[31:ADDR_W+2]!=0
- FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0.
  - On accept with error -> ERR1. On accept, no error, WAIT_STATES=0 -> DONE. On accept, no error, WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle. Counter=0 -> DONE.
  - DONE: hreadyout=1, hresp=0; the data phase completes at this edge.
  - On leaving DONE, the accept condition is evaluated again. It either starts the next transfer (pipelined, no bubble) or goes to IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2. Wait states are not applied to errors.
  - ERR2: hreadyout=1, hresp=1. The accept condition is evaluated as in DONE.
- Writes:
  - hwdata is sampled at the DONE edge only. It is written to mem[addr[ADDR_W+1:2]] through byte enables. Errored writes are never committed.
  - size 0: lane addr[1:0] gets hwdata[8*lane+7:8*lane].
  - size 1: lanes {addr[1],0} and {addr[1],1} get the matching halfword.
  - size 2: all four lanes.
  - Little-endian.
- Reads:
  - In DONE, hrdata = full word mem[registered addr], whatever the size; the master selects lanes.
  - hrdata=0 in all other states.
  - A read issued while the previous write is in its DONE cycle returns the newly written data.
- Inputs hburst, hprot, hmastlock: hburst is sampled but has no effect; hprot and hmastlock are ignored. Every beat is a single transfer addressed by haddr.
- Simultaneous events: reset wins over accept. The accept condition is only ever evaluated in IDLE, DONE or ERR2, because hready is low otherwise.

Test Plan:
- Write word: WAIT_STATES=0, write 0xDEADBEEF to 0x10, then read 0x10.
  -> Each data phase has hreadyout=1 in the first cycle and hresp=0.
  -> Read hrdata=0xDEADBEEF.
- Wait states: WAIT_STATES=2, read 0x10.
  -> hreadyout pattern 0,0,1 and hrdata valid only in the third cycle.
- Byte lanes: word 0x00000000 at 0x20, then byte write 0xAA to 0x21 and halfword write 0x1234 to 0x22.
  -> Reading 0x20 returns 0x1234AA00.
- Errors: word write to 0x13; then hsize=3 to 0x20; then address 0x400 with DEPTH=256.
  -> Each gives hresp=1 for two cycles, hreadyout 0 then 1. Memory is unchanged (re-read 0x10 = 0xDEADBEEF).
- Pipelined: NONSEQ write 0x55 to 0x30, then SEQ read 0x30 back-to-back.
  -> No idle cycle between transfers; read returns 0x00000055.
- Reset: hresetn low during WAIT (WAIT_STATES=3) of a write 0xFFFFFFFF to 0x10.
  -> Next edge gives hreadyout=1, hresp=0, hrdata=0. Re-read 0x10 returns 0xDEADBEEF.
